kyber_cbd: RTL and testbench

//  Kyber centered-binomial-distribution sampler: maps a 192-byte PRF output to 256 small signed

---
 rtl/kyber_pkg.sv | 10 +
 rtl/cbd_coeff.sv | 39 +++
 rtl/kyber_cbd.sv | 48 ++++
 tb/tb_kyber_cbd.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants: polynomial size, CBD coefficient width and eta encodings.
package kyber_pkg;
  localparam int KYBER_N   = 256;
  localparam int CBD_BW    = 3;
  localparam int CBD_NBYTE = 192;
  localparam int CBD_IBITS = 8 * CBD_NBYTE;

  localparam logic [1:0] ETA2 = 2'd2;
  localparam logic [1:0] ETA3 = 2'd3;
endpackage

// File: rtl/cbd_coeff.sv
// One CBD coefficient: 6 raw stream bits + eta in, 3-bit two's complement coefficient out.
// Combinational; the eta=3 popcount only exists when CBD_ETA3_EN is defined.
module cbd_coeff
  import kyber_pkg::*;
(
  input  logic [5:0]        raw,
  input  logic [1:0]        eta,
  output logic [CBD_BW-1:0] coeff
);

  logic [1:0] pos2, neg2;
  assign pos2 = {1'b0, raw[0]} + {1'b0, raw[1]};
  assign neg2 = {1'b0, raw[2]} + {1'b0, raw[3]};

`ifdef CBD_ETA3_EN
  logic [1:0] pos3, neg3;
  // Three single bits sum to at most 3, so 2 bits suffice.
  assign pos3 = {1'b0, raw[0]} + {1'b0, raw[1]} + {1'b0, raw[2]};
  assign neg3 = {1'b0, raw[3]} + {1'b0, raw[4]} + {1'b0, raw[5]};

  always_comb begin
    coeff = '0;
    if (eta == ETA2)
      coeff = {1'b0, pos2} - {1'b0, neg2};
    else if (eta == ETA3)
      coeff = {1'b0, pos3} - {1'b0, neg3};
  end
`else
  logic unused_raw_hi;
  assign unused_raw_hi = ^raw[5:4];

  always_comb begin
    coeff = '0;
    if (eta == ETA2)
      coeff = {1'b0, pos2} - {1'b0, neg2};
  end
`endif

endmodule

// File: rtl/kyber_cbd.sv
// Kyber CBD sampler (192 PRF bytes -> 256 coeffs); eta=3 path built only with CBD_ETA3_EN.
// Latency 1 cycle, 1 vector/cycle, no backpressure; o_coeffs holds when i_valid is low.
module kyber_cbd
  import kyber_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_valid,
  input  logic [CBD_IBITS-1:0]        i_ibytes,
  input  logic [1:0]                  i_eta,
  output logic                        o_valid,
  output logic [KYBER_N*CBD_BW-1:0]   o_coeffs
);

  logic [KYBER_N*CBD_BW-1:0] coeffs_c;

  for (genvar n = 0; n < KYBER_N; n++) begin : g_coef
    logic [5:0] raw;
`ifdef CBD_ETA3_EN
    // eta=3 consumes 6 bits per coefficient, eta=2 only 4.
    assign raw = (i_eta == ETA3) ? i_ibytes[6*n +: 6] : {2'b00, i_ibytes[4*n +: 4]};
`else
    assign raw = {2'b00, i_ibytes[4*n +: 4]};
`endif
    cbd_coeff u_coeff (
      .raw   (raw),
      .eta   (i_eta),
      .coeff (coeffs_c[CBD_BW*n +: CBD_BW])
    );
  end

`ifndef CBD_ETA3_EN
  logic unused_upper_bytes;
  assign unused_upper_bytes = ^i_ibytes[CBD_IBITS-1:4*KYBER_N];
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid  <= 1'b0;
      o_coeffs <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid)
        o_coeffs <= coeffs_c;
    end
  end

endmodule

// File: tb/tb_kyber_cbd.sv
// Directed and random checks of kyber_cbd against a word-form reference cbd2/cbd3 model.
module tb_kyber_cbd;
`ifdef CBD_ETA3_EN
  localparam bit ETA3_ON = 1'b1;
`else
  localparam bit ETA3_ON = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic          valid;
  logic [1535:0] ibytes;
  logic [1:0]    eta;
  logic          o_valid;
  logic [767:0]  o_coeffs;

  int errors = 0;
  int checks = 0;

  kyber_cbd dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_valid  (valid),
    .i_ibytes (ibytes),
    .i_eta    (eta),
    .o_valid  (o_valid),
    .o_coeffs (o_coeffs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Kyber cbd in its 32-bit (eta=2) / 24-bit (eta=3) word form.
  function automatic logic [767:0] ref_cbd(input logic [1535:0] ib, input logic [1:0] e);
    logic [767:0] r;
    logic [31:0]  t, d;
    int a, b;
    r = '0;
    if (e == 2'd2) begin
      for (int i = 0; i < 32; i++) begin
        t = ib[32*i +: 32];
        d = (t & 32'h55555555) + ((t >> 1) & 32'h55555555);
        for (int j = 0; j < 8; j++) begin
          a = int'((d >> (4*j)) & 32'd3);
          b = int'((d >> (4*j+2)) & 32'd3);
          r[3*(8*i+j) +: 3] = 3'(a - b);
        end
      end
    end else if (e == 2'd3 && ETA3_ON) begin
      for (int i = 0; i < 64; i++) begin
        t = {8'h00, ib[24*i +: 24]};
        d = (t & 32'h00249249) + ((t >> 1) & 32'h00249249) + ((t >> 2) & 32'h00249249);
        for (int j = 0; j < 4; j++) begin
          a = int'((d >> (6*j)) & 32'd7);
          b = int'((d >> (6*j+3)) & 32'd7);
          r[3*(4*i+j) +: 3] = 3'(a - b);
        end
      end
    end
    return r;
  endfunction

  task automatic send(input logic [1535:0] b, input logic [1:0] e, input logic v);
    @(negedge clk);
    ibytes = b;
    eta    = e;
    valid  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [1535:0] b;
    b = '0;
    b[7:0] = 8'h03;
    send(b, 2'd2, 1'b1);
    // Assert reset mid-cycle, away from any clock edge.
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_coeffs !== '0) begin
      errors++;
      $display("FAIL reset_async: valid=%b coeffs_nonzero=%b, want valid=0 coeffs=0",
               o_valid, |o_coeffs);
    end
    @(negedge clk);
    rstn  = 1'b1;
    valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0 || o_coeffs !== '0) begin
      errors++;
      $display("FAIL reset_release_idle: valid=%b coeffs_nonzero=%b", o_valid, |o_coeffs);
    end
  endtask

  task automatic test_zero;
    for (int e = 2; e <= 3; e++) begin
      send('0, 2'(e), 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_coeffs !== '0) begin
        errors++;
        $display("FAIL zero_eta%0d: valid=%b coeffs=%h, want valid=1 coeffs=0", e, o_valid, o_coeffs);
      end
    end
  endtask

  task automatic test_eta2_single;
    logic [7:0]   pat [3];
    logic [2:0]   want [3];
    logic [1535:0] b;
    logic [767:0]  exp;
    pat[0] = 8'h03; want[0] = 3'b010;
    pat[1] = 8'h0C; want[1] = 3'b110;
    pat[2] = 8'h01; want[2] = 3'b001;
    for (int k = 0; k < 3; k++) begin
      b = '0; b[7:0] = pat[k];
      exp = '0; exp[2:0] = want[k];
      send(b, 2'd2, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_coeffs !== exp) begin
        errors++;
        $display("FAIL eta2_byte0_%h: valid=%b c0=%b rest_nonzero=%b, want c0=%b rest=0",
                 pat[k], o_valid, o_coeffs[2:0], |o_coeffs[767:3], want[k]);
      end
    end
  endtask

  task automatic test_eta3_single;
    logic [1535:0] b;
    logic [767:0]  exp;
    // byte0=0x07 -> +3
    b = '0; b[7:0] = 8'h07;
    exp = '0; exp[2:0] = ETA3_ON ? 3'b011 : 3'b000;
    send(b, 2'd3, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_coeffs !== exp) begin
      errors++;
      $display("FAIL eta3_byte0_07: valid=%b c0=%b, want c0=%b", o_valid, o_coeffs[2:0], exp[2:0]);
    end
    // byte0=0x38 -> -3
    b = '0; b[7:0] = 8'h38;
    exp = '0; exp[2:0] = ETA3_ON ? 3'b101 : 3'b000;
    send(b, 2'd3, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_coeffs !== exp) begin
      errors++;
      $display("FAIL eta3_byte0_38: valid=%b c0=%b, want c0=%b", o_valid, o_coeffs[2:0], exp[2:0]);
    end
    // byte191=0xFC covers c255 fully (3-3=0); c254's two top bits are clear.
    b = '0; b[1535:1528] = 8'hFC;
    send(b, 2'd3, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_coeffs !== '0) begin
      errors++;
      $display("FAIL eta3_byte191_FC: c254=%b c255=%b, want 000 000", o_coeffs[764:762], o_coeffs[767:765]);
    end
    // byte191=0xFE additionally sets bit 1529 -> c254 = 0-1.
    b = '0; b[1535:1528] = 8'hFE;
    exp = '0; exp[764:762] = ETA3_ON ? 3'b111 : 3'b000;
    send(b, 2'd3, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_coeffs !== exp) begin
      errors++;
      $display("FAIL eta3_byte191_FE: c254=%b c255=%b, want %b 000",
               o_coeffs[764:762], o_coeffs[767:765], exp[764:762]);
    end
  endtask

  task automatic test_saturated;
    logic [1535:0] b;
    b = '1;
    for (int e = 2; e <= 3; e++) begin
      send(b, 2'(e), 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_coeffs !== '0) begin
        errors++;
        $display("FAIL saturated_eta%0d: coeffs=%h, want 0", e, o_coeffs);
      end
    end
    b = '0;
    b[1535:1024] = {16{32'hA5F3_C96E}};
    send(b, 2'd2, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_coeffs !== '0) begin
      errors++;
      $display("FAIL eta2_upper_ignored: coeffs=%h, want 0", o_coeffs);
    end
  endtask

  task automatic test_illegal_eta;
    logic [1535:0] b;
    b = '0; b[7:0] = 8'h03; b[63:32] = 32'h1234_5678;
    for (int e = 0; e <= 1; e++) begin
      send(b, 2'(e), 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_coeffs !== '0) begin
        errors++;
        $display("FAIL illegal_eta%0d: valid=%b coeffs=%h, want valid=1 coeffs=0", e, o_valid, o_coeffs);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1535:0] b;
    logic [1:0]    e;
    logic [767:0]  exp;
    for (int v = 0; v < 50; v++) begin
      for (int w = 0; w < 48; w++) b[32*w +: 32] = $urandom;
      e = 2'($urandom_range(2, 3));
      exp = ref_cbd(b, e);
      send(b, e, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_coeffs !== exp) begin
        errors++;
        $display("FAIL random_%0d_eta%0d: valid=%b got=%h want=%h", v, e, o_valid,
                 o_coeffs[255:0], exp[255:0]);
      end
    end
  endtask

  task automatic test_hold_gap;
    logic [1535:0] b;
    logic [767:0]  exp;
    for (int w = 0; w < 48; w++) b[32*w +: 32] = $urandom;
    exp = ref_cbd(b, 2'd2);
    send(b, 2'd2, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_coeffs !== exp) begin
      errors++;
      $display("FAIL gap_load: valid=%b coeffs mismatch on first vector", o_valid);
    end
    b = ~b;
    for (int k = 0; k < 2; k++) begin
      send(b, 2'd2, 1'b0);
      checks++;
      if (o_valid !== 1'b0 || o_coeffs !== exp) begin
        errors++;
        $display("FAIL gap_hold_%0d: valid=%b coeffs_changed=%b, want valid=0 held",
                 k, o_valid, o_coeffs !== exp);
      end
    end
  endtask

  initial begin
    rstn   = 1'b0;
    valid  = 1'b0;
    ibytes = '0;
    eta    = 2'd2;
    #12;
    checks++;
    if (o_valid !== 1'b0 || o_coeffs !== '0) begin
      errors++;
      $display("FAIL reset_initial: valid=%b coeffs_nonzero=%b", o_valid, |o_coeffs);
    end
    @(negedge clk);
    rstn = 1'b1;

    test_reset;
    test_zero;
    test_eta2_single;
    test_eta3_single;
    test_saturated;
    test_illegal_eta;
    test_back_to_back;
    test_hold_gap;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
